// File: rtl/mac_seq_pkg.sv
// ----------------------------------------------------------------------------
// mac_seq_pkg
// Shared definitions for the dot-product sequencer.
//   - mac_seq_state_e : sequencer FSM state encoding
//   - FP32_ZERO       : IEEE-754 +0.0, fed to the MAC when no pair is accepted
//   - DEF_MAC_LAT     : default MAC latency (multiplier stage + adder stage)
//   - DEF_LEN_W       : default width of the vector-length field and counter
// ----------------------------------------------------------------------------
package mac_seq_pkg;

    localparam int          DEF_MAC_LAT = 2;
    localparam int          DEF_LEN_W   = 16;
    localparam logic [31:0] FP32_ZERO   = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } mac_seq_state_e;

endpackage : mac_seq_pkg

// File: rtl/mac_dot_sequencer.sv
// ----------------------------------------------------------------------------
// mac_dot_sequencer
// Runs one floating-point dot product on an external pipelined MAC. A start
// command latches the vector length, the MAC is held in clear while its
// pipeline flushes, operand pairs are streamed in, zeros are fed while the
// pipeline drains, and the final accumulator is offered on a result handshake.
//
// Optional feature: define MAC_SEQ_ABORT_EN to add the abort input, which
// returns any non-IDLE state to IDLE at the next edge without a result.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, vec_len    start command and number of operand pairs (IDLE only)
//   busy              high whenever the FSM is not in IDLE
//   in_valid/in_ready operand pair handshake, in_a/in_b operands (FP32)
//   mac_clr           active-high clear to the MAC
//   mac_x1, mac_x2    registered MAC operands (zero unless a pair was taken)
//   mac_acc           MAC accumulator output
//   res_valid/res_ready, res_data   result handshake and registered result
//   abort             (MAC_SEQ_ABORT_EN only) cancel the running sequence
//   dbg_state         current FSM state, for observation only
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high. in_ready and res_valid are decoded from the registered
// state alone, so neither has a combinational path from its partner signal.
// ----------------------------------------------------------------------------
module mac_dot_sequencer
    import mac_seq_pkg::*;
#(
    parameter int MAC_LAT = DEF_MAC_LAT,
    parameter int LEN_W   = DEF_LEN_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LEN_W-1:0]     vec_len,
    output logic                 busy,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_a,
    input  logic [31:0]          in_b,
    output logic                 mac_clr,
    output logic [31:0]          mac_x1,
    output logic [31:0]          mac_x2,
    input  logic [31:0]          mac_acc,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [31:0]          res_data,
`ifdef MAC_SEQ_ABORT_EN
    input  logic                 abort,
`endif
    output mac_seq_state_e       dbg_state
);

    // Shared CLEAR/DRAIN cycle counter; it must reach MAC_LAT.
    localparam int               CYC_W    = $clog2(MAC_LAT + 1);
    localparam logic [CYC_W-1:0] CLR_LAST = CYC_W'(MAC_LAT - 1);
    localparam logic [CYC_W-1:0] DRN_LAST = CYC_W'(MAC_LAT);

    mac_seq_state_e   state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic             zero_len_q, zero_len_d;
    logic [31:0]      x1_q, x1_d;
    logic [31:0]      x2_q, x2_d;
    logic [31:0]      res_data_q, res_data_d;
    logic             accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rem_q      <= '0;
            cyc_q      <= '0;
            zero_len_q <= 1'b0;
            x1_q       <= FP32_ZERO;
            x2_q       <= FP32_ZERO;
            res_data_q <= FP32_ZERO;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            cyc_q      <= cyc_d;
            zero_len_q <= zero_len_d;
            x1_q       <= x1_d;
            x2_q       <= x2_d;
            res_data_q <= res_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        cyc_d      = cyc_q;
        zero_len_d = zero_len_q;
        x1_d       = FP32_ZERO;
        x2_d       = FP32_ZERO;
        res_data_d = res_data_q;

        busy      = (state_q != ST_IDLE);
        in_ready  = (state_q == ST_FEED);
        res_valid = (state_q == ST_DONE);
        // The MAC only runs while pairs stream in and the pipeline drains.
        mac_clr   = (state_q == ST_IDLE) || (state_q == ST_CLEAR) ||
                    (state_q == ST_DONE);
        accept    = in_ready && in_valid;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (vec_len != '0) begin
                        rem_d      = vec_len;
                        cyc_d      = '0;
                        zero_len_d = 1'b0;
                        state_d    = ST_CLEAR;
                    end else begin
                        // Empty vector: spend one cycle in DRAIN at its final
                        // count so the result appears one edge after start,
                        // with the captured value forced to zero.
                        rem_d      = '0;
                        cyc_d      = DRN_LAST;
                        zero_len_d = 1'b1;
                        state_d    = ST_DRAIN;
                    end
                end
            end
            ST_CLEAR: begin
                if (cyc_q == CLR_LAST) begin
                    cyc_d   = '0;
                    state_d = ST_FEED;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            ST_FEED: begin
                if (accept) begin
                    x1_d  = in_a;
                    x2_d  = in_b;
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        cyc_d   = '0;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // MAC_LAT+1 zero cycles: the last pair reaches mac_acc after
                // MAC_LAT edges, sampled on the following edge.
                if (cyc_q == DRN_LAST) begin
                    res_data_d = zero_len_q ? FP32_ZERO : mac_acc;
                    cyc_d      = '0;
                    state_d    = ST_DONE;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    zero_len_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef MAC_SEQ_ABORT_EN
        // Abort overrides every handshake in the same cycle.
        if (abort && (state_q != ST_IDLE)) begin
            state_d    = ST_IDLE;
            rem_d      = '0;
            cyc_d      = '0;
            zero_len_d = 1'b0;
            x1_d       = FP32_ZERO;
            x2_d       = FP32_ZERO;
        end
`endif
    end

    assign mac_x1    = x1_q;
    assign mac_x2    = x2_q;
    assign res_data  = res_data_q;
    assign dbg_state = state_q;

endmodule : mac_dot_sequencer
